inventory_dispenser: RTL and testbench
======================================

// Module: inventory_dispenser
// PURPOSE
//  Per-item stock store and dispense controller, directly downstream of the payment stage.
//  Answers the payment stage's reduce_inventory request with a four-phase handshake.
//  On each accepted request it decrements the selected item's count and runs the
//  dispense motor for a fixed time. Drives full_inventory back to the payment stage.
//  Accepts restock writes from the service port.
// PARAMETERS
//  NUM_ITEMS        8   number of product slots; cur_index and restock_index must be < NUM_ITEMS
//  CNT_W            4   width of each stock counter; saturates at 2**CNT_W-1
//  INIT_COUNT       10  stock loaded into every slot at reset
//  DISPENSE_CYCLES  4   number of clk cycles dispense_motor stays high per vend (>=1)
// PORTS
//  clk                    in   1          clock, rising edge
//  rst                    in   1          reset: synchronous, active-high
//  cur_index              in   4          currently selected item from the selection stage
//  reduce_inventory       in   1          vend request from the payment stage (four-phase req)
//  reduce_inventory_done  out  1          vend acknowledge (four-phase ack)
//  full_inventory         out  1          1 = the item at cur_index has stock > 0
//  restock_valid          in   1          restock write request
//  restock_ready          out  1          restock is accepted this cycle (valid && ready)
//  restock_index          in   4          slot to restock
//  restock_qty            in   CNT_W      quantity added to that slot
//  dispense_motor         out  1          motor drive, high for DISPENSE_CYCLES per vend
//  dispense_index         out  4          slot being vended; held until the next vend
//  dispense_err           out  1          one-cycle pulse: request hit an empty or invalid slot
//  sold_out_mask          out  NUM_ITEMS  bit i = 1 when count[i] == 0
// BEHAVIOUR
//  Reset
//   - All counts are set to INIT_COUNT.
//   - All outputs are 0, except sold_out_mask, which reflects the reset counts (0 if INIT_COUNT>0).
//   - FSM goes to IDLE. A reset in any state aborts the vend and drops the motor next cycle.
//  FSM: IDLE -> DISPENSE -> ACK -> IDLE
//   - IDLE, reduce_inventory=1, index valid, count>0:
//     - latch cur_index into dispense_index; decrement that count
//     - go to DISPENSE, motor=1, load timer = DISPENSE_CYCLES-1
//   - IDLE, reduce_inventory=1, count==0 or cur_index>=NUM_ITEMS:
//     - pulse dispense_err, no decrement, go straight to ACK
//   - DISPENSE: motor stays 1 while the timer counts down; timer==0 -> motor=0, go to ACK.
//   - ACK: reduce_inventory_done=1; hold it until reduce_inventory==0, then done=0 and go to IDLE.
//   - A new request is taken only in IDLE. A request that is still high after done drops is not re-accepted.
//   - Latency: request seen -> motor high next cycle -> done high DISPENSE_CYCLES+1 cycles after the request.
//  full_inventory
//   - Registered; value = (cur_index<NUM_ITEMS) && count[cur_index]!=0.
//   - Forced to 0 while state!=IDLE, so the payment stage cannot double-charge mid-vend.
//  Restock
//   - restock_ready = (state==IDLE) && !reduce_inventory.
//   - On valid&&ready: count[idx] = min(count[idx]+qty, 2**CNT_W-1); the add uses CNT_W+1 bits.
//   - Invalid restock_index: accepted and ignored.
//   - A request arriving in the same cycle wins; the restock waits (ready=0).
//  Counters never wrap: there is no decrement at 0 and no increment past saturation.
// CONFIGURATION
//  INV_LOW_STOCK_ALERT_EN defined:
//   - adds param LOW_THRESH (default 2) and output low_stock_mask[NUM_ITEMS-1:0].
//   - bit i = 1 when 0 < count[i] <= LOW_THRESH; registered; reset value reflects INIT_COUNT.
//  Not defined: no port, no param, no logic.
// STRUCTURE
//  Shared package vend_pkg holds:
//   - state encoding localparams (ST_IDLE=2'd0, ST_DISPENSE=2'd1, ST_ACK=2'd2)
//   - NUM_ITEMS and index width, shared with the payment stage.
//  Sub-module dispense_timer: loadable down-counter with a motor-enable output and a zero flag.
//  Count storage is a flat register array in the top module.
// TESTING
//  1. reset, then cur_index=3 -> full_inventory=1, sold_out_mask=0, all counts 10.
//  2. reduce_inventory=1 at idx 3 -> motor high for 4 cycles; done=1 at cycle 5; count[3]=9;
//     drop req -> done=0 one cycle later.
//  3. Vend idx 5 ten times -> full_inventory=0, sold_out_mask[5]=1;
//     11th request -> dispense_err pulse, no motor, done still completes.
//  4. restock idx 0 qty 15 at count 10 -> count saturates at 15; restock_valid during DISPENSE -> ready=0.
//  5. Assert rst mid-DISPENSE -> motor=0 and done=0 next cycle; counts back to 10.
//  6. INV_LOW_STOCK_ALERT_EN: vend idx 1 eight times -> low_stock_mask[1]=1 at count 2;
//     ninth and tenth vends -> low_stock_mask[1]=0, sold_out_mask[1]=1.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared vending definitions: FSM state encoding and slot geometry.
// The payment stage imports the same slot count and index width.
package vend_pkg;

  localparam int NUM_ITEMS = 8;
  localparam int IDX_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPENSE = 2'd1,
    ST_ACK      = 2'd2
  } state_t;

endpackage

// File: rtl/dispense_timer.sv
// Loadable down-counter that keeps the dispense motor running for a fixed
// number of cycles. motor_en is high from the load until the count at zero
// has been spent; zero flags the final motor cycle.
module dispense_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         motor_en,
  output logic         zero
);

  logic [W-1:0] cnt;
  logic         active;

  // Count down once per cycle after a load; stop when the zero cycle is spent.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (load) begin
      cnt    <= load_value;
      active <= 1'b1;
    end else if (active) begin
      if (cnt == '0) begin
        active <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign motor_en = active;
  assign zero     = (cnt == '0);

endmodule

// File: rtl/inventory_dispenser.sv
// Per-item stock store and vend controller sitting after the payment stage.
// Answers reduce_inventory with a four-phase handshake, decrements the chosen
// slot, runs the motor for DISPENSE_CYCLES and accepts service restocks.
// Optional feature: define INV_LOW_STOCK_ALERT_EN to add the LOW_THRESH
// parameter and the registered low_stock_mask output.
module inventory_dispenser #(
  parameter int NUM_ITEMS       = vend_pkg::NUM_ITEMS,
  parameter int CNT_W           = 4,
  parameter int INIT_COUNT      = 10,
  parameter int DISPENSE_CYCLES = 4
`ifdef INV_LOW_STOCK_ALERT_EN
  ,
  parameter int LOW_THRESH      = 2
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [vend_pkg::IDX_W-1:0] cur_index,
  input  logic                       reduce_inventory,
  output logic                       reduce_inventory_done,
  output logic                       full_inventory,
  input  logic                       restock_valid,
  output logic                       restock_ready,
  input  logic [vend_pkg::IDX_W-1:0] restock_index,
  input  logic [CNT_W-1:0]           restock_qty,
  output logic                       dispense_motor,
  output logic [vend_pkg::IDX_W-1:0] dispense_index,
  output logic                       dispense_err,
  output logic [NUM_ITEMS-1:0]       sold_out_mask
`ifdef INV_LOW_STOCK_ALERT_EN
  ,
  output logic [NUM_ITEMS-1:0]       low_stock_mask
`endif
);

  import vend_pkg::*;

  localparam int SEL_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
  localparam int TMR_W = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INIT_COUNT);

  state_t               state;
  state_t               state_next;
  logic [CNT_W-1:0]     count      [NUM_ITEMS];
  logic [CNT_W-1:0]     count_next [NUM_ITEMS];
  logic [SEL_W-1:0]     cur_sel;
  logic [SEL_W-1:0]     restock_sel;
  logic [CNT_W:0]       restock_sum;
  logic                 cur_valid;
  logic                 cur_has_stock;
  logic                 restock_idx_valid;
  logic                 accept;
  logic                 reject;
  logic                 restock_fire;
  logic                 timer_zero;
  logic                 motor_en;
  logic                 full_q;
  logic                 err_q;

  assign cur_valid         = 32'(cur_index) < NUM_ITEMS;
  assign restock_idx_valid = 32'(restock_index) < NUM_ITEMS;
  assign cur_sel           = cur_index[SEL_W-1:0];
  assign restock_sel       = restock_index[SEL_W-1:0];
  assign cur_has_stock     = cur_valid && (count[cur_sel] != '0);
  assign accept            = (state == ST_IDLE) && reduce_inventory && cur_has_stock;
  assign reject            = (state == ST_IDLE) && reduce_inventory && !cur_has_stock;
  assign restock_fire      = restock_valid && restock_ready;
  assign restock_sum       = {1'b0, count[restock_sel]} + {1'b0, restock_qty};

  dispense_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .load_value (TMR_W'(DISPENSE_CYCLES - 1)),
    .motor_en   (motor_en),
    .zero       (timer_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: empty/invalid requests skip the motor phase and go straight to ACK.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_DISPENSE;
        end else if (reject) begin
          state_next = ST_ACK;
        end
      end
      ST_DISPENSE: begin
        if (timer_zero) begin
          state_next = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!reduce_inventory) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs: full_inventory is masked outside IDLE so a vend cannot be charged twice.
  always_comb begin
    reduce_inventory_done = (state == ST_ACK);
    dispense_motor        = motor_en;
    dispense_err          = err_q;
    full_inventory        = full_q && (state == ST_IDLE);
    restock_ready         = (state == ST_IDLE) && !reduce_inventory && !rst;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      sold_out_mask[i] = (count[i] == '0);
    end
  end

  // Stock update: a vend decrements, a restock adds with saturation; never both at once.
  always_comb begin
    for (int i = 0; i < NUM_ITEMS; i++) begin
      count_next[i] = count[i];
    end
    if (accept) begin
      count_next[cur_sel] = count[cur_sel] - 1'b1;
    end else if (restock_fire && restock_idx_valid) begin
      count_next[restock_sel] = restock_sum[CNT_W] ? CNT_MAX : restock_sum[CNT_W-1:0];
    end
  end

  // Stock registers, the latched vend slot, the error pulse and the stock flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        count[i] <= CNT_INIT;
      end
      full_q         <= 1'b0;
      err_q          <= 1'b0;
      dispense_index <= '0;
    end else begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        count[i] <= count_next[i];
      end
      full_q <= cur_has_stock;
      err_q  <= reject;
      if (accept) begin
        dispense_index <= cur_index;
      end
    end
  end

`ifdef INV_LOW_STOCK_ALERT_EN
  localparam logic [CNT_W-1:0] LOW_LIM  = CNT_W'(LOW_THRESH);
  localparam logic             LOW_INIT = (INIT_COUNT > 0) && (INIT_COUNT <= LOW_THRESH);

  logic [NUM_ITEMS-1:0] low_q;

  // Low-stock flags track the same next-count values as the stock registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      low_q <= {NUM_ITEMS{LOW_INIT}};
    end else begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        low_q[i] <= (count_next[i] != '0) && (count_next[i] <= LOW_LIM);
      end
    end
  end

  assign low_stock_mask = low_q;
`endif

endmodule

// File: tb/tb_inventory_dispenser.sv
// Self-checking bench for inventory_dispenser: table-driven vends with a
// scoreboard of expected vend outcomes, plus hand-written sequences for
// saturation, restock arbitration and reset mid-vend.
// Define INV_LOW_STOCK_ALERT_EN to also cover low_stock_mask.
module tb_inventory_dispenser;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cur_index;
  logic       reduce_inventory;
  logic       reduce_inventory_done;
  logic       full_inventory;
  logic       restock_valid;
  logic       restock_ready;
  logic [3:0] restock_index;
  logic [3:0] restock_qty;
  logic       dispense_motor;
  logic [3:0] dispense_index;
  logic       dispense_err;
  logic [7:0] sold_out_mask;
`ifdef INV_LOW_STOCK_ALERT_EN
  logic [7:0] low_stock_mask;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  int model_cnt [8];
  logic [3:0] last_disp = 4'd0;

  typedef struct {
    logic [3:0] idx;
    logic       exp_err;
    logic       exp_full;
    logic [7:0] exp_sold;
  } vec_t;

  typedef struct {
    logic [3:0] idx;
    int         err_pulses;
    int         motor_cycles;
    int         latency;
    logic [3:0] disp_idx;
  } exp_t;

  exp_t sb_q[$];

  inventory_dispenser dut (
    .clk                   (clk),
    .rst                   (rst),
    .cur_index             (cur_index),
    .reduce_inventory      (reduce_inventory),
    .reduce_inventory_done (reduce_inventory_done),
    .full_inventory        (full_inventory),
    .restock_valid         (restock_valid),
    .restock_ready         (restock_ready),
    .restock_index         (restock_index),
    .restock_qty           (restock_qty),
    .dispense_motor        (dispense_motor),
    .dispense_index        (dispense_index),
    .dispense_err          (dispense_err),
    .sold_out_mask         (sold_out_mask)
`ifdef INV_LOW_STOCK_ALERT_EN
    ,
    .low_stock_mask        (low_stock_mask)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: actual %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic model_empty(input logic [3:0] idx);
    if (int'(idx) >= 8) return 1'b1;
    return model_cnt[idx] == 0;
  endfunction

  function automatic void model_take(input logic [3:0] idx);
    if (int'(idx) < 8 && model_cnt[idx] > 0) model_cnt[idx]--;
  endfunction

  task automatic check_masks(input string tag);
    logic [7:0] sold;
    for (int i = 0; i < 8; i++) sold[i] = (model_cnt[i] == 0);
    check_output({tag, " sold_out_mask"}, sold_out_mask, sold);
`ifdef INV_LOW_STOCK_ALERT_EN
    begin
      logic [7:0] low;
      for (int i = 0; i < 8; i++) low[i] = (model_cnt[i] > 0) && (model_cnt[i] <= 2);
      check_output({tag, " low_stock_mask"}, low_stock_mask, low);
    end
`endif
  endtask

  // One complete vend through the handshake; the expected outcome is queued
  // when the request is driven and compared once the acknowledge arrives.
  task automatic apply_stimulus(input logic [3:0] idx, input logic exp_err);
    exp_t e;
    int   motor_hi = 0;
    int   err_hi   = 0;
    int   lat      = -1;
    int   full_hi  = 0;
    cur_index = idx;
    tick();
    e.idx          = idx;
    e.err_pulses   = exp_err ? 1 : 0;
    e.motor_cycles = exp_err ? 0 : 4;
    e.latency      = exp_err ? 1 : 5;
    e.disp_idx     = exp_err ? last_disp : idx;
    sb_q.push_back(e);
    reduce_inventory = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (dispense_motor) motor_hi++;
      if (dispense_err) err_hi++;
      if (full_inventory) full_hi++;
      if (reduce_inventory_done) begin
        lat = c;
        break;
      end
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      if (dispense_err) err_hi++;
      if (full_inventory) full_hi++;
      check_output("done held while req high", reduce_inventory_done, 1);
    end
    reduce_inventory = 1'b0;
    tick();
    check_output("done drops after req", reduce_inventory_done, 0);
    check_output("motor idle after vend", dispense_motor, 0);
    e = sb_q.pop_front();
    check_output("vend latency", lat, e.latency);
    check_output("motor cycles", motor_hi, e.motor_cycles);
    check_output("err pulses", err_hi, e.err_pulses);
    check_output("dispense_index", dispense_index, e.disp_idx);
    check_output("full masked mid-vend", full_hi, 0);
    last_disp = e.disp_idx;
    model_take(idx);
    check_masks("after vend");
  endtask

  task automatic do_restock(input logic [3:0] idx, input logic [3:0] qty);
    restock_index = idx;
    restock_qty   = qty;
    restock_valid = 1'b1;
    #1;
    check_output("restock_ready idle", restock_ready, 1);
    tick();
    restock_valid = 1'b0;
    if (int'(idx) < 8) model_cnt[idx] = (model_cnt[idx] + int'(qty) > 15) ? 15 : model_cnt[idx] + int'(qty);
    tick();
    check_masks("after restock");
  endtask

  // Finish a vend that was started by hand: wait for done, release, update model.
  task automatic finish_manual_vend(input logic [3:0] idx);
    int lat = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (reduce_inventory_done) begin
        lat = c;
        break;
      end
    end
    check_output("manual vend done seen", (lat > 0) ? 1 : 0, 1);
    reduce_inventory = 1'b0;
    tick();
    check_output("manual vend done drops", reduce_inventory_done, 0);
    last_disp = idx;
    model_take(idx);
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{idx: 4'd3,  exp_err: 1'b0, exp_full: 1'b1, exp_sold: 8'h00};
    vecs[1] = '{idx: 4'd9,  exp_err: 1'b1, exp_full: 1'b0, exp_sold: 8'h00};
    vecs[2] = '{idx: 4'd0,  exp_err: 1'b0, exp_full: 1'b1, exp_sold: 8'h00};
    vecs[3] = '{idx: 4'd7,  exp_err: 1'b0, exp_full: 1'b1, exp_sold: 8'h00};
    vecs[4] = '{idx: 4'd15, exp_err: 1'b1, exp_full: 1'b0, exp_sold: 8'h00};

    rst = 1'b1;
    cur_index = 4'd0;
    reduce_inventory = 1'b0;
    restock_valid = 1'b0;
    restock_index = 4'd0;
    restock_qty = 4'd0;
    for (int i = 0; i < 8; i++) model_cnt[i] = 10;

    // Reset state
    tick();
    tick();
    check_output("reset motor", dispense_motor, 0);
    check_output("reset done", reduce_inventory_done, 0);
    check_output("reset err", dispense_err, 0);
    check_output("reset full", full_inventory, 0);
    check_output("reset ready", restock_ready, 0);
    check_output("reset dispense_index", dispense_index, 0);
    check_output("reset sold_out_mask", sold_out_mask, 0);
`ifdef INV_LOW_STOCK_ALERT_EN
    check_output("reset low_stock_mask", low_stock_mask, 0);
`endif
    rst = 1'b0;
    cur_index = 4'd3;
    tick();
    check_output("full at idx 3", full_inventory, 1);
    check_output("ready after reset", restock_ready, 1);

    // Table-driven vends
    for (int v = 0; v < 5; v++) begin
      apply_stimulus(vecs[v].idx, vecs[v].exp_err);
      check_output("table full_inventory", full_inventory, vecs[v].exp_full);
      check_output("table sold_out_mask", sold_out_mask, vecs[v].exp_sold);
    end

    // Empty slot 5, then one more request must error
    for (int k = 0; k < 10; k++) apply_stimulus(4'd5, model_empty(4'd5));
    check_output("idx5 full after 10 vends", full_inventory, 0);
    check_output("idx5 sold out", sold_out_mask, 8'h20);
    apply_stimulus(4'd5, 1'b1);

    // Saturating restock of slot 0 (count 9 + 15 -> 15), proven by draining it
    do_restock(4'd0, 4'd15);
    for (int k = 0; k < 15; k++) apply_stimulus(4'd0, model_empty(4'd0));
    apply_stimulus(4'd0, 1'b1);
    do_restock(4'd5, 4'd3);
    do_restock(4'd12, 4'd5);

    // Restock offered while dispensing must be held off
    cur_index = 4'd2;
    tick();
    reduce_inventory = 1'b1;
    tick();
    tick();
    restock_valid = 1'b1;
    restock_index = 4'd0;
    restock_qty = 4'd7;
    #1;
    check_output("ready during dispense", restock_ready, 0);
    tick();
    check_output("ready during dispense 2", restock_ready, 0);
    restock_valid = 1'b0;
    finish_manual_vend(4'd2);
    check_masks("after blocked restock");

    // Request and restock in the same cycle: the request wins
    reduce_inventory = 1'b1;
    restock_valid = 1'b1;
    #1;
    check_output("ready vs same-cycle request", restock_ready, 0);
    tick();
    restock_valid = 1'b0;
    finish_manual_vend(4'd2);
    check_masks("after collision");

    // Reset in the middle of a vend
    cur_index = 4'd4;
    tick();
    reduce_inventory = 1'b1;
    tick();
    tick();
    check_output("motor before reset", dispense_motor, 1);
    rst = 1'b1;
    reduce_inventory = 1'b0;
    tick();
    check_output("motor after mid-vend reset", dispense_motor, 0);
    check_output("done after mid-vend reset", reduce_inventory_done, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) model_cnt[i] = 10;
    last_disp = 4'd0;
    cur_index = 4'd5;
    tick();
    check_output("dispense_index cleared", dispense_index, 0);
    check_output("idx5 restored by reset", full_inventory, 1);
    check_masks("after reset");

`ifdef INV_LOW_STOCK_ALERT_EN
    // Drain slot 1 watching the low-stock flag rise at 2 and fall at 0
    for (int k = 0; k < 10; k++) begin
      apply_stimulus(4'd1, model_empty(4'd1));
      if (k == 6) check_output("low[1] at count 3", low_stock_mask[1], 0);
      if (k == 7) check_output("low[1] at count 2", low_stock_mask[1], 1);
    end
    check_output("low[1] at count 0", low_stock_mask[1], 0);
    check_output("sold[1] at count 0", sold_out_mask[1], 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
